// File: rtl/aibcr3aux_actred_ctrl.sv
// rtl/aibcr3aux_actred_ctrl.sv - active-redundancy chain shift controller
// Shifts two configuration chains LSB first, captures the loopback and flags per-chain mismatches.
module aibcr3aux_actred_ctrl #(
   parameter int NBITS = 16,
   parameter int RXLAT = 2
) (
   input  logic             osc_clk,
   input  logic             dig_rstb,
   input  logic             start,
   input  logic             csr_actred_txen,
   input  logic [1:0]       csr_actred_chain_en,
   input  logic [NBITS-1:0] csr_actred_chain1_cfg,
   input  logic [NBITS-1:0] csr_actred_chain2_cfg,
   input  logic             rx_chain1,
   input  logic             rx_chain2,
   output logic             actred_chain1,
   output logic             actred_chain2,
   output logic             actred_shiften_chain1,
   output logic             actred_shiften_chain2,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [1:0]       err
);

   localparam int CW = $clog2(NBITS + RXLAT + 1);
   localparam logic [CW-1:0] LAST_SHIFT = CW'(NBITS - 1);
   localparam logic [CW-1:0] LAST_DRAIN = CW'(NBITS + RXLAT - 1);
   localparam logic [CW-1:0] FIRST_CAP  = CW'(RXLAT);

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, CHECK} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [NBITS-1:0] tx1, tx2, snap1, snap2, cap1, cap2;
   logic [1:0]       en_q;
   logic             accept, running;
   logic             d1_nxt, d2_nxt, s1_nxt, s2_nxt, done_nxt, busy_nxt;

   assign accept  = (state == IDLE) && start && csr_actred_txen;
   assign running = (state == SHIFT || state == DRAIN) && csr_actred_txen;

   always_ff @(posedge osc_clk or negedge dig_rstb) begin
      if (!dig_rstb) state <= IDLE;
      else           state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (accept) state_nxt = SHIFT;
         SHIFT: if (!csr_actred_txen)    state_nxt = IDLE;
                else if (cnt == LAST_SHIFT) state_nxt = DRAIN;
         DRAIN: if (!csr_actred_txen)    state_nxt = IDLE;
                else if (cnt == LAST_DRAIN) state_nxt = CHECK;
         CHECK: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of the registered outputs; the first bit comes straight from cfg on the start edge.
   always_comb begin
      d1_nxt   = 1'b0;
      d2_nxt   = 1'b0;
      s1_nxt   = 1'b0;
      s2_nxt   = 1'b0;
      done_nxt = (state == CHECK) && csr_actred_txen;
      busy_nxt = (state_nxt != IDLE);
      if (state == IDLE && state_nxt == SHIFT) begin
         s1_nxt = csr_actred_chain_en[0];
         s2_nxt = csr_actred_chain_en[1];
         d1_nxt = csr_actred_chain_en[0] & csr_actred_chain1_cfg[0];
         d2_nxt = csr_actred_chain_en[1] & csr_actred_chain2_cfg[0];
      end else if (state == SHIFT && state_nxt == SHIFT) begin
         s1_nxt = en_q[0];
         s2_nxt = en_q[1];
         d1_nxt = en_q[0] & tx1[0];
         d2_nxt = en_q[1] & tx2[0];
      end
   end

   always_ff @(posedge osc_clk or negedge dig_rstb) begin
      if (!dig_rstb) begin
         actred_chain1         <= 1'b0;
         actred_chain2         <= 1'b0;
         actred_shiften_chain1 <= 1'b0;
         actred_shiften_chain2 <= 1'b0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
      end else begin
         actred_chain1         <= d1_nxt;
         actred_chain2         <= d2_nxt;
         actred_shiften_chain1 <= s1_nxt;
         actred_shiften_chain2 <= s2_nxt;
         busy                  <= busy_nxt;
         done                  <= done_nxt;
      end
   end

   // cnt tracks the cycle index from the first SHIFT output through the last DRAIN cycle.
   always_ff @(posedge osc_clk or negedge dig_rstb) begin
      if (!dig_rstb) begin
         cnt     <= '0;
         tx1     <= '0;
         tx2     <= '0;
         snap1   <= '0;
         snap2   <= '0;
         cap1    <= '0;
         cap2    <= '0;
         en_q    <= 2'b00;
         aborted <= 1'b0;
         err     <= 2'b00;
      end else if (accept) begin
         cnt     <= '0;
         tx1     <= {1'b0, csr_actred_chain1_cfg[NBITS-1:1]};
         tx2     <= {1'b0, csr_actred_chain2_cfg[NBITS-1:1]};
         snap1   <= csr_actred_chain1_cfg;
         snap2   <= csr_actred_chain2_cfg;
         cap1    <= '0;
         cap2    <= '0;
         en_q    <= csr_actred_chain_en;
         aborted <= 1'b0;
         err     <= 2'b00;
      end else begin
         if (state != IDLE && !csr_actred_txen) aborted <= 1'b1;
         if (running) begin
            cnt <= cnt + CW'(1);
            if (state == SHIFT) begin
               tx1 <= {1'b0, tx1[NBITS-1:1]};
               tx2 <= {1'b0, tx2[NBITS-1:1]};
            end
            if (cnt >= FIRST_CAP) begin
               cap1 <= {rx_chain1, cap1[NBITS-1:1]};
               cap2 <= {rx_chain2, cap2[NBITS-1:1]};
            end
         end
         if (state == CHECK && csr_actred_txen)
            err <= {en_q[1] && (cap2 != snap2), en_q[0] && (cap1 != snap1)};
      end
   end

endmodule
